// File: rtl/atm_pkg.sv
`timescale 1ns/1ps
// Shared constants for the ATM keypad front end: field widths, key codes, menu codes, FSM states.
package atm_pkg;

  localparam int ACC_W    = 12;
  localparam int PIN_W    = 4;
  localparam int AMT_W    = 11;
  localparam int MENU_W   = 3;
  localparam int ACC_DIG  = 4;
  localparam int PIN_DIG  = 2;
  localparam int MENU_DIG = 1;
  localparam int CALC_W   = ACC_W + 4;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [3:0] KEY_LANG   = 4'hD;

  localparam logic [MENU_W-1:0] BALANCE               = 3'd3;
  localparam logic [MENU_W-1:0] WITHDRAW              = 3'd4;
  localparam logic [MENU_W-1:0] WITHDRAW_SHOW_BALANCE = 3'd5;
  localparam logic [MENU_W-1:0] TRANSACTION           = 3'd6;
  localparam logic [MENU_W-1:0] DEPOSIT               = 3'd7;

  localparam logic LANG_ENGLISH = 1'b0;
  localparam logic LANG_ARABIC  = 1'b1;

  typedef enum logic [2:0] {
    S_ACC   = 3'd0,
    S_PIN   = 3'd1,
    S_MENU  = 3'd2,
    S_DEST  = 3'd3,
    S_AMT   = 3'd4,
    S_ISSUE = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_digit_accum.sv
`timescale 1ns/1ps
// Decimal field accumulator: value*10+digit with range and digit-count limits.
// Value and count update the cycle after an accepted digit; reject is combinational.
module atm_digit_accum
  import atm_pkg::*;
#(
  parameter int W      = ACC_W,
  parameter int MAX    = (1 << ACC_W) - 1,
  parameter int MAXDIG = ACC_DIG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dig_vld_i,
  input  logic [3:0]   dig_i,
  input  logic         clr_i,
  output logic [W-1:0] value_o,
  output logic [2:0]   ndig_o,
  output logic         reject_o
);

  localparam logic [CALC_W-1:0] MAX_L    = CALC_W'(MAX);
  localparam logic [2:0]        MAXDIG_L = 3'(MAXDIG);

  logic [W-1:0]      value_q, value_d;
  logic [2:0]        ndig_q, ndig_d;
  logic [CALC_W-1:0] next_val;
  logic              fits;
  logic              accept;

  always_comb begin
    next_val = CALC_W'(value_q) * CALC_W'(10) + CALC_W'(dig_i);
    fits     = (next_val <= MAX_L) && (ndig_q < MAXDIG_L);
    accept   = dig_vld_i && fits;
    reject_o = dig_vld_i && !fits;
    value_d  = value_q;
    ndig_d   = ndig_q;
    if (clr_i) begin
      value_d = '0;
      ndig_d  = '0;
    end else if (accept) begin
      value_d = next_val[W-1:0];
      ndig_d  = ndig_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      ndig_q  <= '0;
    end else begin
      value_q <= value_d;
      ndig_q  <= ndig_d;
    end
  end

  assign value_o = value_q;
  assign ndig_o  = ndig_q;

endmodule

// File: rtl/atm_keypad_frontend.sv
`timescale 1ns/1ps
// Keypad-to-request front end: FSM over account/PIN/menu/dest/amount fields, valid/ready issue.
// Key effects appear one cycle later; req_valid and all fields hold until req_ready accepts.
module atm_keypad_frontend
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [ACC_W-1:0]  acc_number,
  output logic [PIN_W-1:0]  pin,
  output logic [MENU_W-1:0] menu_option,
  output logic [AMT_W-1:0]  amount,
  output logic [ACC_W-1:0]  dest_acc,
  output logic              lang,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              exit_o,
  output logic              entry_err
);

  state_t state_q, state_d;
  logic   lang_q, lang_d;
  logic   err_q, err_d;
  logic   exit_q, exit_d;
  logic   req_valid_q;

  logic is_dig, is_enter, is_clear, is_cancel, is_lang, hs;
  logic acc_dig, pin_dig, menu_dig, amt_dig, dest_dig;
  logic acc_clr, pin_clr, menu_clr, amt_clr, dest_clr;
  logic acc_rej, pin_rej, menu_rej, amt_rej, dest_rej;
  logic [2:0] acc_nd, pin_nd, menu_nd, amt_nd, dest_nd, cur_nd;
  logic cur_rej, menu_ok, enter_ok, enter_bad;

  assign is_dig    = key_valid && is_digit(key_code);
  assign is_enter  = key_valid && (key_code == KEY_ENTER);
  assign is_clear  = key_valid && (key_code == KEY_CLEAR);
  assign is_cancel = key_valid && (key_code == KEY_CANCEL);
  assign is_lang   = key_valid && (key_code == KEY_LANG);
  assign hs        = req_valid_q && req_ready;

  always_comb begin
    cur_nd  = '0;
    cur_rej = 1'b0;
    case (state_q)
      S_ACC:   begin cur_nd = acc_nd;  cur_rej = acc_rej;  end
      S_PIN:   begin cur_nd = pin_nd;  cur_rej = pin_rej;  end
      S_MENU:  begin cur_nd = menu_nd; cur_rej = menu_rej; end
      S_DEST:  begin cur_nd = dest_nd; cur_rej = dest_rej; end
      S_AMT:   begin cur_nd = amt_nd;  cur_rej = amt_rej;  end
      default: ;
    endcase
  end

  assign menu_ok   = (menu_option >= BALANCE);
  assign enter_ok  = is_enter && (cur_nd != 3'd0) && (state_q != S_MENU || menu_ok);
  assign enter_bad = is_enter && (state_q != S_ISSUE) && !enter_ok;
  assign err_d     = cur_rej || enter_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      lang_q      <= LANG_ENGLISH;
      err_q       <= 1'b0;
      exit_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lang_q      <= lang_d;
      err_q       <= err_d;
      exit_q      <= exit_d;
      req_valid_q <= (state_d == S_ISSUE);
    end
  end

  // Cancel outranks everything, including a handshake landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (is_cancel) begin
      state_d = S_ACC;
    end else begin
      case (state_q)
        S_ACC:   if (enter_ok) state_d = S_PIN;
        S_PIN:   if (enter_ok) state_d = S_MENU;
        S_MENU: begin
          if (enter_ok) begin
            case (menu_option)
              BALANCE:     state_d = S_ISSUE;
              TRANSACTION: state_d = S_DEST;
              WITHDRAW, WITHDRAW_SHOW_BALANCE, DEPOSIT: state_d = S_AMT;
              default:     state_d = S_MENU;
            endcase
          end
        end
        S_DEST:  if (enter_ok) state_d = S_AMT;
        S_AMT:   if (enter_ok) state_d = S_ISSUE;
        S_ISSUE: if (hs) state_d = S_MENU;
        default: state_d = S_ACC;
      endcase
    end
  end

  always_comb begin
    acc_dig  = is_dig && (state_q == S_ACC);
    pin_dig  = is_dig && (state_q == S_PIN);
    menu_dig = is_dig && (state_q == S_MENU);
    dest_dig = is_dig && (state_q == S_DEST);
    amt_dig  = is_dig && (state_q == S_AMT);
    acc_clr  = is_cancel || (is_clear && state_q == S_ACC);
    pin_clr  = is_cancel || (is_clear && state_q == S_PIN);
    menu_clr = is_cancel || hs || (is_clear && state_q == S_MENU)
               || (enter_bad && state_q == S_MENU);
    dest_clr = is_cancel || hs || (is_clear && state_q == S_DEST);
    amt_clr  = is_cancel || hs || (is_clear && state_q == S_AMT);
    exit_d   = is_cancel;
    lang_d   = lang_q;
    if (is_lang && state_q != S_ISSUE)
      lang_d = (lang_q == LANG_ARABIC) ? LANG_ENGLISH : LANG_ARABIC;
  end

  atm_digit_accum #(.W(ACC_W), .MAX((1 << ACC_W) - 1), .MAXDIG(ACC_DIG)) u_acc (
    .clk(clk), .rst(rst), .dig_vld_i(acc_dig), .dig_i(key_code), .clr_i(acc_clr),
    .value_o(acc_number), .ndig_o(acc_nd), .reject_o(acc_rej)
  );

  atm_digit_accum #(.W(PIN_W), .MAX((1 << PIN_W) - 1), .MAXDIG(PIN_DIG)) u_pin (
    .clk(clk), .rst(rst), .dig_vld_i(pin_dig), .dig_i(key_code), .clr_i(pin_clr),
    .value_o(pin), .ndig_o(pin_nd), .reject_o(pin_rej)
  );

  atm_digit_accum #(.W(MENU_W), .MAX((1 << MENU_W) - 1), .MAXDIG(MENU_DIG)) u_menu (
    .clk(clk), .rst(rst), .dig_vld_i(menu_dig), .dig_i(key_code), .clr_i(menu_clr),
    .value_o(menu_option), .ndig_o(menu_nd), .reject_o(menu_rej)
  );

  atm_digit_accum #(.W(AMT_W), .MAX((1 << AMT_W) - 1), .MAXDIG(ACC_DIG)) u_amt (
    .clk(clk), .rst(rst), .dig_vld_i(amt_dig), .dig_i(key_code), .clr_i(amt_clr),
    .value_o(amount), .ndig_o(amt_nd), .reject_o(amt_rej)
  );

  atm_digit_accum #(.W(ACC_W), .MAX((1 << ACC_W) - 1), .MAXDIG(ACC_DIG)) u_dest (
    .clk(clk), .rst(rst), .dig_vld_i(dest_dig), .dig_i(key_code), .clr_i(dest_clr),
    .value_o(dest_acc), .ndig_o(dest_nd), .reject_o(dest_rej)
  );

  assign lang      = lang_q;
  assign req_valid = req_valid_q;
  assign exit_o    = exit_q;
  assign entry_err = err_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
`timescale 1ns/1ps
// Directed bench for atm_keypad_frontend: session entry, issue handshake, limits, cancel, language.
module tb_atm_keypad_frontend;
  import atm_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_valid = 1'b0;
  logic [3:0]        key_code = 4'h0;
  logic              req_ready = 1'b0;
  logic [ACC_W-1:0]  acc_number, dest_acc;
  logic [PIN_W-1:0]  pin;
  logic [MENU_W-1:0] menu_option;
  logic [AMT_W-1:0]  amount;
  logic              lang, req_valid, exit_o, entry_err;

  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int hs0;
  int hs_acc, hs_menu, hs_amt, hs_dest;

  atm_keypad_frontend dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .acc_number(acc_number), .pin(pin), .menu_option(menu_option), .amount(amount),
    .dest_acc(dest_acc), .lang(lang), .req_valid(req_valid), .req_ready(req_ready),
    .exit_o(exit_o), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      hs_cnt  = hs_cnt + 1;
      hs_acc  = int'(acc_number);
      hs_menu = int'(menu_option);
      hs_amt  = int'(amount);
      hs_dest = int'(dest_acc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want self-termination");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Keys are packed as hex nibbles, first key in the most significant used nibble.
  task automatic type_keys(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) press(s[4*(n-1-i) +: 4]);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; req_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (acc_number !== 12'd0) $display("FAIL rst_acc got=%0d want=0", acc_number); else n_pass++;
    n_chk++; if (pin !== 4'd0) $display("FAIL rst_pin got=%0d want=0", pin); else n_pass++;
    n_chk++; if (menu_option !== 3'd0) $display("FAIL rst_menu got=%0d want=0", menu_option); else n_pass++;
    n_chk++; if (amount !== 11'd0) $display("FAIL rst_amt got=%0d want=0", amount); else n_pass++;
    n_chk++; if (dest_acc !== 12'd0) $display("FAIL rst_dest got=%0d want=0", dest_acc); else n_pass++;
    n_chk++; if ({lang, req_valid, exit_o, entry_err} !== 4'b0000)
      $display("FAIL rst_flags got=%b want=0000", {lang, req_valid, exit_o, entry_err}); else n_pass++;
  endtask

  task automatic test_balance;
    do_reset();
    type_keys(64'h2178, 4);
    n_chk++; if (acc_number !== 12'd2178) $display("FAIL bal_acc_entry got=%0d want=2178", acc_number); else n_pass++;
    type_keys(64'hA4A3, 4);
    n_chk++; if (menu_option !== 3'd3) $display("FAIL bal_menu_entry got=%0d want=3", menu_option); else n_pass++;
    req_ready = 1'b1;
    hs0 = hs_cnt;
    press(KEY_ENTER);
    n_chk++; if (req_valid !== 1'b1) $display("FAIL bal_req_valid got=%b want=1", req_valid); else n_pass++;
    n_chk++; if ({acc_number, pin, menu_option} !== {12'd2178, 4'd4, 3'd3})
      $display("FAIL bal_fields got acc=%0d pin=%0d menu=%0d want 2178/4/3", acc_number, pin, menu_option); else n_pass++;
    n_chk++; if ({amount, dest_acc} !== {11'd0, 12'd0})
      $display("FAIL bal_amt_dest got amt=%0d dest=%0d want 0/0", amount, dest_acc); else n_pass++;
    tick();
    req_ready = 1'b0;
    n_chk++; if (req_valid !== 1'b0) $display("FAIL bal_req_drop got=%b want=0", req_valid); else n_pass++;
    n_chk++; if (hs_cnt !== hs0 + 1) $display("FAIL bal_hs_count got=%0d want=%0d", hs_cnt, hs0 + 1); else n_pass++;
    n_chk++; if ({acc_number, pin, menu_option} !== {12'd2178, 4'd4, 3'd0})
      $display("FAIL bal_after_hs got acc=%0d pin=%0d menu=%0d want 2178/4/0", acc_number, pin, menu_option); else n_pass++;
  endtask

  task automatic test_back_to_back;
    type_keys(64'h6A2429A, 7);
    n_chk++; if (dest_acc !== 12'd2429) $display("FAIL xfer_dest got=%0d want=2429", dest_acc); else n_pass++;
    type_keys(64'h100A, 4);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if ({req_valid, dest_acc, amount} !== {1'b1, 12'd2429, 11'd100})
        $display("FAIL xfer_hold cyc=%0d got v=%b dest=%0d amt=%0d want 1/2429/100", i, req_valid, dest_acc, amount); else n_pass++;
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_chk++; if ({req_valid, dest_acc, amount} !== {1'b0, 12'd0, 11'd0})
      $display("FAIL xfer_clear got v=%b dest=%0d amt=%0d want 0/0/0", req_valid, dest_acc, amount); else n_pass++;
    n_chk++; if (hs_cnt !== hs0 + 1 || hs_dest != 2429 || hs_amt != 100 || hs_menu != 6)
      $display("FAIL xfer_hs got n=%0d dest=%0d amt=%0d menu=%0d want %0d/2429/100/6", hs_cnt, hs_dest, hs_amt, hs_menu, hs0 + 1); else n_pass++;
  endtask

  task automatic test_overflow;
    type_keys(64'h4A204, 5);
    n_chk++; if ({amount, entry_err} !== {11'd204, 1'b0}) $display("FAIL ovf_amt_entry got amt=%0d err=%b want 204/0", amount, entry_err); else n_pass++;
    press(4'd8);
    n_chk++; if ({amount, entry_err} !== {11'd204, 1'b1}) $display("FAIL ovf_amt_reject got amt=%0d err=%b want 204/1", amount, entry_err); else n_pass++;
    tick();
    n_chk++; if (entry_err !== 1'b0) $display("FAIL ovf_err_pulse got=%b want=0", entry_err); else n_pass++;
    press(KEY_CANCEL);
    type_keys(64'h500, 3);
    press(4'd0);
    n_chk++; if ({acc_number, entry_err} !== {12'd500, 1'b1}) $display("FAIL ovf_acc_reject got acc=%0d err=%b want 500/1", acc_number, entry_err); else n_pass++;
    press(KEY_CLEAR);
    n_chk++; if ({acc_number, entry_err} !== {12'd0, 1'b0}) $display("FAIL ovf_clear got acc=%0d err=%b want 0/0", acc_number, entry_err); else n_pass++;
    type_keys(64'h00012, 5);
    n_chk++; if ({acc_number, entry_err} !== {12'd1, 1'b1}) $display("FAIL ovf_digit_limit got acc=%0d err=%b want 1/1", acc_number, entry_err); else n_pass++;
  endtask

  task automatic test_menu;
    press(KEY_CLEAR);
    type_keys(64'h12A9A, 5);
    press(KEY_ENTER);
    n_chk++; if (entry_err !== 1'b1) $display("FAIL menu_empty_enter got=%b want=1", entry_err); else n_pass++;
    press(4'd2);
    n_chk++; if ({menu_option, entry_err} !== {3'd2, 1'b0}) $display("FAIL menu_digit got menu=%0d err=%b want 2/0", menu_option, entry_err); else n_pass++;
    press(KEY_ENTER);
    n_chk++; if ({menu_option, entry_err} !== {3'd0, 1'b1}) $display("FAIL menu_bad_code got menu=%0d err=%b want 0/1", menu_option, entry_err); else n_pass++;
    type_keys(64'h7A5, 3);
    req_ready = 1'b1;
    hs0 = hs_cnt;
    press(KEY_ENTER);
    n_chk++; if ({req_valid, menu_option, amount, acc_number, pin} !== {1'b1, 3'd7, 11'd5, 12'd12, 4'd9})
      $display("FAIL menu_deposit got v=%b menu=%0d amt=%0d acc=%0d pin=%0d want 1/7/5/12/9", req_valid, menu_option, amount, acc_number, pin); else n_pass++;
    tick();
    req_ready = 1'b0;
    n_chk++; if (req_valid !== 1'b0 || hs_cnt !== hs0 + 1 || hs_menu != 7 || hs_amt != 5)
      $display("FAIL menu_deposit_hs got v=%b n=%0d menu=%0d amt=%0d want 0/%0d/7/5", req_valid, hs_cnt, hs_menu, hs_amt, hs0 + 1); else n_pass++;
  endtask

  task automatic test_cancel;
    type_keys(64'h4A37, 4);
    n_chk++; if (amount !== 11'd37) $display("FAIL cxl_amt got=%0d want=37", amount); else n_pass++;
    press(KEY_CANCEL);
    n_chk++; if (exit_o !== 1'b1) $display("FAIL cxl_exit got=%b want=1", exit_o); else n_pass++;
    n_chk++; if ({acc_number, pin, menu_option, amount, dest_acc, req_valid} !== '0)
      $display("FAIL cxl_fields got acc=%0d pin=%0d menu=%0d amt=%0d dest=%0d v=%b want all 0", acc_number, pin, menu_option, amount, dest_acc, req_valid); else n_pass++;
    tick();
    n_chk++; if (exit_o !== 1'b0) $display("FAIL cxl_exit_pulse got=%b want=0", exit_o); else n_pass++;
    press(4'd3);
    n_chk++; if (acc_number !== 12'd3) $display("FAIL cxl_back_to_acc got=%0d want=3", acc_number); else n_pass++;
    type_keys(64'hA1A3A, 5);
    n_chk++; if (req_valid !== 1'b1) $display("FAIL cxl_issue got=%b want=1", req_valid); else n_pass++;
    hs0 = hs_cnt;
    req_ready = 1'b1;
    press(KEY_CANCEL);
    req_ready = 1'b0;
    n_chk++; if (hs_cnt !== hs0 + 1 || hs_acc != 3) $display("FAIL cxl_hs_counted got n=%0d acc=%0d want %0d/3", hs_cnt, hs_acc, hs0 + 1); else n_pass++;
    n_chk++; if ({req_valid, exit_o, acc_number} !== {1'b0, 1'b1, 12'd0})
      $display("FAIL cxl_hs_after got v=%b exit=%b acc=%0d want 0/1/0", req_valid, exit_o, acc_number); else n_pass++;
    press(4'd5);
    n_chk++; if (acc_number !== 12'd5) $display("FAIL cxl_hs_state got acc=%0d want=5", acc_number); else n_pass++;
  endtask

  task automatic test_lang;
    do_reset();
    press(4'hF);
    n_chk++; if ({acc_number, entry_err} !== {12'd0, 1'b0}) $display("FAIL lang_key_f got acc=%0d err=%b want 0/0", acc_number, entry_err); else n_pass++;
    type_keys(64'h1A, 2);
    press(KEY_LANG);
    n_chk++; if (lang !== 1'b1) $display("FAIL lang_toggle_pin got=%b want=1", lang); else n_pass++;
    type_keys(64'h1A3A, 4);
    press(KEY_LANG);
    n_chk++; if ({lang, req_valid, entry_err} !== 3'b110) $display("FAIL lang_in_issue got lang=%b v=%b err=%b want 1/1/0", lang, req_valid, entry_err); else n_pass++;
    press(4'hE);
    press(4'd7);
    n_chk++; if ({req_valid, menu_option, entry_err} !== {1'b1, 3'd3, 1'b0})
      $display("FAIL lang_issue_ignore got v=%b menu=%0d err=%b want 1/3/0", req_valid, menu_option, entry_err); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({req_valid, lang, exit_o, acc_number, pin, menu_option} !== '0)
      $display("FAIL lang_rst_issue got v=%b lang=%b exit=%b acc=%0d pin=%0d menu=%0d want all 0", req_valid, lang, exit_o, acc_number, pin, menu_option); else n_pass++;
    type_keys(64'h45, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({acc_number, exit_o, entry_err} !== {12'd0, 1'b0, 1'b0})
      $display("FAIL lang_rst_entry got acc=%0d exit=%b err=%b want 0/0/0", acc_number, exit_o, entry_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_balance();
    test_back_to_back();
    test_overflow();
    test_menu();
    test_cancel();
    test_lang();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
